// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//
// Bundle between the multicycle control FSM and the MIPS-lite datapath.
//
//   Datapath -> control : opcode[5:0] (IR[31:26]), mem_ready
//   Control -> datapath : pc_write, pc_write_cond, pc_source[1:0], i_or_d,
//                         mem_read, mem_write, ir_write, reg_dst[1:0],
//                         mem_to_reg[1:0], reg_write, alu_src_a,
//                         alu_src_b[1:0], alu_op[1:0]
//   Status              : state[3:0], illegal, retired[15:0]
//
// modport master : the control FSM (drives strobes and status)
// modport slave  : the datapath / memory side (drives opcode and mem_ready)
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;

    logic [3:0]  state;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, state, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, state, illegal, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multicycle control FSM for the MIPS-lite datapath (R-type, lw, sw, beq, j,
// jal). Sequences the shared memory port, register file, ALU and PC through
// fetch/decode/execute/memory/writeback steps, stalling on mem_ready during
// memory accesses. Also keeps a 16-bit retired-instruction counter and a
// sticky illegal-opcode flag.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mips_multicycle_ctrl_if.master (opcode/mem_ready in,
//            datapath control strobes, state, illegal, retired out)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    state_e      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    // Raw (pre-reset-gating) control decode
    logic        pc_write_c;
    logic        pc_write_cond_c;
    logic [1:0]  pc_source_c;
    logic        i_or_d_c;
    logic        mem_read_c;
    logic        mem_write_c;
    logic        ir_write_c;
    logic [1:0]  reg_dst_c;
    logic [1:0]  mem_to_reg_c;
    logic        reg_write_c;
    logic        alu_src_a_c;
    logic [1:0]  alu_src_b_c;
    logic [1:0]  alu_op_c;

    // ------------------------------------------------------------------
    // Next-state, retire and illegal-flag logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        retire    = 1'b0;

        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:          state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Opcode is looked at again here; anything that is no longer a
            // load/store abandons the instruction without retiring it.
            S_MEMADR: begin
                if (bus.opcode == OP_LW)
                    state_d = S_MEMRD;
                else if (bus.opcode == OP_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_FETCH;
            end
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB, S_BRANCH, S_JUMP, S_JAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase

        // 16-bit add wraps FFFF -> 0 naturally
        retired_d = retire ? (retired_q + 16'd1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the state register. The only input-dependent
    // terms are ir_write/pc_write in FETCH, gated by mem_ready.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pc_source_c     = 2'b00;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_dst_c       = 2'b00;
        mem_to_reg_c    = 2'b00;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            S_RWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
            end
            // PC already holds PC+4 here, so $31 gets the return address
            S_JAL: begin
                pc_write_c   = 1'b1;
                pc_source_c  = 2'b10;
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
            end
            default: ;
        endcase
    end

    // While rst_n is low every strobe is forced off, even FETCH's mem_read,
    // so nothing reaches memory or the register file during reset.
    assign bus.pc_write      = rst_n & pc_write_c;
    assign bus.pc_write_cond = rst_n & pc_write_cond_c;
    assign bus.pc_source     = {2{rst_n}} & pc_source_c;
    assign bus.i_or_d        = rst_n & i_or_d_c;
    assign bus.mem_read      = rst_n & mem_read_c;
    assign bus.mem_write     = rst_n & mem_write_c;
    assign bus.ir_write      = rst_n & ir_write_c;
    assign bus.reg_dst       = {2{rst_n}} & reg_dst_c;
    assign bus.mem_to_reg    = {2{rst_n}} & mem_to_reg_c;
    assign bus.reg_write     = rst_n & reg_write_c;
    assign bus.alu_src_a     = rst_n & alu_src_a_c;
    assign bus.alu_src_b     = {2{rst_n}} & alu_src_b_c;
    assign bus.alu_op        = {2{rst_n}} & alu_op_c;

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS-lite datapath. It sequences one shared memory port, the register file, the ALU and the PC through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. The instruction set is R-type, lw, sw, beq, j and jal. Memory accesses stall on a ready handshake, and the block keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- No parameters. Opcode values and state encodings are fixed below.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction bits [31:26], taken from the datapath instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when ALU zero is 1.
- pc_source  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- reg_dst  out  2  write register: 00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 PC, 1 register A.
- alu_src_b  out  2  ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- alu_op  out  2  to ALU control: 00 add, 01 subtract, 10 funct field.
- state  out  4  current state encoding.
- illegal  out  1  sticky; an unsupported opcode has been decoded.
- retired  out  16  count of completed instructions.

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, JAL 10. Codes 11–15 are unreachable; if entered, go to FETCH.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE
  - Outputs: alu_src_b=11, alu_op=00.
  - Next state by opcode: R→EXEC, lw/sw→MEMADR, beq→BRANCH, j→JUMP, jal→JAL.
  - Any other opcode: go to FETCH and set illegal.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw→MEMRD, sw→MEMWR. Opcode is re-sampled here.
- MEMRD: mem_read=1, i_or_d=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=01, reg_dst=00. Next: FETCH.
- MEMWR
  - Outputs: mem_write=1, i_or_d=1.
  - Stay until mem_ready=1, then go to FETCH. mem_write is held high for every wait cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- JAL
  - Outputs: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
  - The PC already holds PC+4 here, so $31 receives the return address.
  - Next: FETCH.
- retired
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or JAL.
  - Illegal opcodes do not count.
  - Wraps from 16'hFFFF to 0.
- illegal is set on the clock edge leaving DECODE with a bad opcode. It is cleared only by reset.

## Timing
- Outputs are decoded from the state register. The only Mealy terms are mem_ready gating ir_write and pc_write in FETCH.
- While rst_n=0:
  - state=FETCH, retired=0, illegal=0.
  - All control outputs are forced to 0, including mem_read.
- Release: the first rising edge after rst_n rises evaluates FETCH normally.
- Reset mid-instruction: state returns to FETCH immediately (asynchronously). Write strobes drop in the same instant. No partial write is issued after reset.
- Cycles per instruction with mem_ready held at 1: R 4, lw 5, sw 4, beq 3, j 3, jal 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in every other state.

## Test plan
- Reset, then R-type with mem_ready=1 → states 0,1,6,7,0. reg_write=1 and reg_dst=01 only in state 7. retired=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total. ir_write pulses exactly once. reg_write with mem_to_reg=01 for one cycle. retired increments by 1.
- sw then beq → MEMWR holds mem_write=1 until mem_ready. BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01. retired=2.
- jal → state 10 drives pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1. Completes in 3 cycles.
- Opcode 111111 → DECODE goes to FETCH, illegal=1 and stays 1 through following valid instructions. retired unchanged.
- Preload retired to 16'hFFFF by running instructions, then retire one more → retired=0. Assert rst_n=0 mid-MEMWR → mem_write=0 immediately, state=0, retired=0.
